// File: rtl/dmem_pkg.sv
// Shared types for the data-memory responder: funct3 encodings, FSM states and the latched request.
package dmem_pkg;

    localparam int DMEM_ADDR_W = 9;
    localparam int DMEM_DATA_W = 32;

    typedef enum logic [2:0] {
        F3_B  = 3'b000,
        F3_H  = 3'b001,
        F3_W  = 3'b010,
        F3_BU = 3'b100,
        F3_HU = 3'b101
    } dmem_funct3_e;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } dmem_state_t;

    typedef struct packed {
        logic                   we;
        logic                   re;
        logic [DMEM_ADDR_W-1:0] addr;
        logic [DMEM_DATA_W-1:0] wdata;
        logic [2:0]             funct3;
    } dmem_req_t;

    // Stores take precedence when both strobes are set; no-ops are never misaligned.
    function automatic logic dmem_misaligned(input logic we, input logic re,
                                             input logic [2:0] funct3, input logic [1:0] lane);
        logic mis;
        mis = 1'b0;
        if (we) begin
            if (funct3 == F3_H)      mis = lane[0];
            else if (funct3 == F3_W) mis = |lane;
        end else if (re) begin
            if (funct3 == F3_H || funct3 == F3_HU) mis = lane[0];
            else if (funct3 == F3_W)               mis = |lane;
        end
        return mis;
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response bus between the pipeline MEM stage (master) and the data-memory responder (slave).
interface dmem_responder_if #(
    parameter int DM_ADDRESS = 9,
    parameter int DATA_W     = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic                  req_re;
    logic [DM_ADDRESS-1:0] req_addr;
    logic [DATA_W-1:0]     req_wdata;
    logic [2:0]            req_funct3;
    logic                  rsp_valid;
    logic [DATA_W-1:0]     rsp_rdata;
    logic                  rsp_err;

    modport master (
        output req_valid, req_we, req_re, req_addr, req_wdata, req_funct3,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_re, req_addr, req_wdata, req_funct3,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dmem_lane_align.sv
// Combinational RV32 byte-lane handling: load extract/extend and store byte-merge selected by funct3.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  lane,
    input  logic [31:0] mem_word,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] store_word,
    output logic        store_en
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign byte_sel = mem_word[{lane, 3'b000} +: 8];
    assign half_sel = lane[1] ? mem_word[31:16] : mem_word[15:0];

    // Unsupported funct3 codes fall through to a zero load and no write.
    always_comb begin
        load_data  = '0;
        store_word = mem_word;
        store_en   = 1'b0;
        case (funct3)
            F3_B: begin
                load_data                       = {{24{byte_sel[7]}}, byte_sel};
                store_word[{lane, 3'b000} +: 8] = wdata[7:0];
                store_en                        = 1'b1;
            end
            F3_H: begin
                load_data = {{16{half_sel[15]}}, half_sel};
                if (lane[1]) store_word[31:16] = wdata[15:0];
                else         store_word[15:0]  = wdata[15:0];
                store_en  = 1'b1;
            end
            F3_W: begin
                load_data  = mem_word;
                store_word = wdata;
                store_en   = 1'b1;
            end
            F3_BU:   load_data = {24'h0, byte_sel};
            F3_HU:   load_data = {16'h0, half_sel};
            default: load_data = '0;
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one request at a time, WAIT_CYCLES wait states, one-cycle response.
// Optional misaligned-access detection is enabled by defining DMEM_MISALIGN_CHECK_EN.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DM_ADDRESS  = DMEM_ADDR_W,
    parameter int DATA_W      = DMEM_DATA_W,
    parameter int WAIT_CYCLES = 1
) (
    input logic             clk,
    input logic             reset,
    dmem_responder_if.slave bus
);

    localparam int WORDS = 2 ** (DM_ADDRESS - 2);

    dmem_state_t           state_q, state_d;
    logic [3:0]            wait_q, wait_d;
    dmem_req_t             req_q, cur_req;
    logic [DATA_W-1:0]     mem [WORDS];
    logic [DATA_W-1:0]     rdata_q;
    logic                  err_q;
    logic [DM_ADDRESS-1:0] cur_addr;
    logic [DM_ADDRESS-3:0] word_idx;
    logic                  accept, commit, misaligned, do_store;
    logic [31:0]           load_data, store_word;
    logic                  store_en;

    assign accept = (state_q == IDLE) && bus.req_valid;

    // With zero wait states the request is committed on the accept edge, straight from the bus.
    always_comb begin
        cur_req = req_q;
        if (state_q == IDLE) begin
            cur_req.we     = bus.req_we;
            cur_req.re     = bus.req_re;
            cur_req.addr   = DMEM_ADDR_W'(bus.req_addr);
            cur_req.wdata  = bus.req_wdata;
            cur_req.funct3 = bus.req_funct3;
        end
    end

    assign cur_addr = DM_ADDRESS'(cur_req.addr);
    assign word_idx = cur_addr[DM_ADDRESS-1:2];
    assign commit   = ((state_q == WAIT) && (wait_q == 4'd0)) || (accept && (WAIT_CYCLES == 0));

    dmem_lane_align u_align (
        .funct3    (cur_req.funct3),
        .lane      (cur_addr[1:0]),
        .mem_word  (mem[word_idx]),
        .wdata     (cur_req.wdata),
        .load_data (load_data),
        .store_word(store_word),
        .store_en  (store_en)
    );

`ifdef DMEM_MISALIGN_CHECK_EN
    assign misaligned = dmem_misaligned(cur_req.we, cur_req.re, cur_req.funct3, cur_addr[1:0]);
`else
    assign misaligned = 1'b0;
`endif

    // Gating with reset keeps a store from landing while the FSM is held in reset.
    assign do_store = reset && commit && cur_req.we && store_en && !misaligned;

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    if (WAIT_CYCLES == 0) begin
                        state_d = RESP;
                        wait_d  = 4'd0;
                    end else begin
                        state_d = WAIT;
                        wait_d  = 4'(WAIT_CYCLES - 1);
                    end
                end
            end
            WAIT: begin
                if (wait_q == 4'd0) state_d = RESP;
                else                wait_d  = wait_q - 4'd1;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            wait_q  <= 4'd0;
            req_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            if (accept) req_q <= cur_req;
            if (commit) begin
                rdata_q <= (cur_req.re && !cur_req.we && !misaligned) ? load_data : '0;
                err_q   <= misaligned;
            end
        end
    end

    // Storage is intentionally left unreset.
    always_ff @(posedge clk) begin
        if (do_store) mem[word_idx] <= store_word;
    end

    assign bus.req_ready = (state_q == IDLE);
    assign bus.rsp_valid = (state_q == RESP);
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: one DUT with one wait state, one with zero wait states.
module tb_dmem_responder;
    import dmem_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    dmem_responder_if #(.DM_ADDRESS(9), .DATA_W(32)) bus ();
    dmem_responder_if #(.DM_ADDRESS(9), .DATA_W(32)) bus_fast ();

    dmem_responder #(.DM_ADDRESS(9), .DATA_W(32), .WAIT_CYCLES(1)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    dmem_responder #(.DM_ADDRESS(9), .DATA_W(32), .WAIT_CYCLES(0)) dut_fast (
        .clk  (clk),
        .reset(reset),
        .bus  (bus_fast)
    );

    // Issues one request, waits (bounded) for the response and reports cycles from accept edge to rsp_valid.
    task automatic transact(input bit fast, input logic we, input logic re, input logic [8:0] addr,
                            input logic [31:0] wdata, input logic [2:0] f3,
                            output logic [31:0] rdata, output logic err, output int lat);
        @(negedge clk);
        if (fast) begin
            bus_fast.req_valid = 1'b1; bus_fast.req_we = we; bus_fast.req_re = re;
            bus_fast.req_addr = addr; bus_fast.req_wdata = wdata; bus_fast.req_funct3 = f3;
        end else begin
            bus.req_valid = 1'b1; bus.req_we = we; bus.req_re = re;
            bus.req_addr = addr; bus.req_wdata = wdata; bus.req_funct3 = f3;
        end
        @(negedge clk);
        bus.req_valid      = 1'b0;
        bus_fast.req_valid = 1'b0;
        lat = 1;
        while (!(fast ? bus_fast.rsp_valid : bus.rsp_valid) && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        rdata = fast ? bus_fast.rsp_rdata : bus.rsp_rdata;
        err   = fast ? bus_fast.rsp_err : bus.rsp_err;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({bus.req_ready, bus.rsp_valid, bus.rsp_err} !== 3'b100 || bus.rsp_rdata !== 32'h0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: ready/valid/err=%b%b%b rdata=%h, required 100 and 00000000",
                     bus.req_ready, bus.rsp_valid, bus.rsp_err, bus.rsp_rdata);
        end
        checks++;
        if ({bus_fast.req_ready, bus_fast.rsp_valid, bus_fast.rsp_err} !== 3'b100 || bus_fast.rsp_rdata !== 32'h0) begin
            errors++;
            $display("[TB] FAIL reset_outputs_fast: ready/valid/err=%b%b%b rdata=%h, required 100 and 00000000",
                     bus_fast.req_ready, bus_fast.rsp_valid, bus_fast.rsp_err, bus_fast.rsp_rdata);
        end
        reset = 1'b1;
    endtask

    task automatic test_word();
        logic [31:0] rd; logic er; int lat;
        transact(1'b0, 1'b1, 1'b0, 9'h010, 32'hDEADBEEF, F3_W, rd, er, lat);
        checks++;
        if (lat !== 2 || rd !== 32'h0 || er !== 1'b0) begin
            errors++;
            $display("[TB] FAIL sw_word: lat=%0d rdata=%h err=%b, required lat=2 rdata=00000000 err=0", lat, rd, er);
        end
        transact(1'b0, 1'b0, 1'b1, 9'h010, 32'h0, F3_W, rd, er, lat);
        checks++;
        if (lat !== 2 || rd !== 32'hDEADBEEF || er !== 1'b0) begin
            errors++;
            $display("[TB] FAIL lw_word: lat=%0d rdata=%h err=%b, required lat=2 rdata=deadbeef err=0", lat, rd, er);
        end
    endtask

    task automatic test_subword_load();
        logic [8:0]  addrs [9] = '{9'h013, 9'h013, 9'h012, 9'h012, 9'h010, 9'h011, 9'h010, 9'h010, 9'h010};
        logic [2:0]  f3s   [9] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b000, 3'b100, 3'b001, 3'b011, 3'b110};
        logic [31:0] exps  [9] = '{32'hFFFFFFDE, 32'h000000DE, 32'hFFFFDEAD, 32'h0000DEAD, 32'hFFFFFFEF,
                                   32'h000000BE, 32'hFFFFBEEF, 32'h00000000, 32'h00000000};
        logic [31:0] rd; logic er; int lat;
        for (int i = 0; i < 9; i++) begin
            transact(1'b0, 1'b0, 1'b1, addrs[i], 32'h0, f3s[i], rd, er, lat);
            checks++;
            if (rd !== exps[i] || er !== 1'b0) begin
                errors++;
                $display("[TB] FAIL load_f3_%b_addr_%h: rdata=%h err=%b, required %h err=0",
                         f3s[i], addrs[i], rd, er, exps[i]);
            end
        end
    endtask

    task automatic test_subword_store();
        // we, re, addr, wdata, funct3 for each store; followed by an LW of the same word.
        logic        wes   [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        logic        res   [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        logic [8:0]  addrs [6] = '{9'h011, 9'h012, 9'h010, 9'h014, 9'h014, 9'h017};
        logic [31:0] wds   [6] = '{32'hAAAAAA12, 32'h5555CAFE, 32'h11111111, 32'h01020304, 32'hFFFFFFFF, 32'h77777799};
        logic [2:0]  f3s   [6] = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b010, 3'b000};
        logic [31:0] exps  [6] = '{32'hDEAD12EF, 32'hCAFE12EF, 32'hCAFE12EF, 32'h01020304, 32'h01020304, 32'h99020304};
        logic [31:0] rd; logic er; int lat;
        logic [8:0]  waddr;
        for (int i = 0; i < 6; i++) begin
            transact(1'b0, wes[i], res[i], addrs[i], wds[i], f3s[i], rd, er, lat);
            checks++;
            if (rd !== 32'h0 || er !== 1'b0) begin
                errors++;
                $display("[TB] FAIL store_rsp_%0d: rdata=%h err=%b, required 00000000 err=0", i, rd, er);
            end
            waddr = {addrs[i][8:2], 2'b00};
            transact(1'b0, 1'b0, 1'b1, waddr, 32'h0, F3_W, rd, er, lat);
            checks++;
            if (rd !== exps[i]) begin
                errors++;
                $display("[TB] FAIL store_readback_%0d: rdata=%h, required %h", i, rd, exps[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic exp_ready, exp_valid;
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_re = 1'b1;
        bus.req_addr = 9'h010; bus.req_wdata = 32'h0; bus.req_funct3 = F3_W;
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            exp_ready = (k % 3 == 2);
            exp_valid = (k % 3 == 1);
            checks++;
            if (bus.req_ready !== exp_ready || bus.rsp_valid !== exp_valid) begin
                errors++;
                $display("[TB] FAIL b2b_cycle_%0d: ready=%b valid=%b, required ready=%b valid=%b",
                         k, bus.req_ready, bus.rsp_valid, exp_ready, exp_valid);
            end
            if (exp_valid) begin
                checks++;
                if (bus.rsp_rdata !== 32'hCAFE12EF) begin
                    errors++;
                    $display("[TB] FAIL b2b_rdata_%0d: rdata=%h, required cafe12ef", k, bus.rsp_rdata);
                end
            end
        end
        bus.req_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1 || bus.rsp_rdata !== 32'hCAFE12EF) begin
            errors++;
            $display("[TB] FAIL b2b_idle_hold: valid=%b ready=%b rdata=%h, required 0 1 cafe12ef",
                     bus.rsp_valid, bus.req_ready, bus.rsp_rdata);
        end
    endtask

    task automatic test_reset_abort();
        logic [31:0] rd; logic er; int lat;
        transact(1'b0, 1'b1, 1'b0, 9'h020, 32'h12345678, F3_W, rd, er, lat);
        transact(1'b0, 1'b0, 1'b1, 9'h010, 32'h0, F3_W, rd, er, lat);
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_re = 1'b0;
        bus.req_addr = 9'h020; bus.req_wdata = 32'h00000055; bus.req_funct3 = F3_W;
        @(negedge clk);
        bus.req_valid = 1'b0;
        checks++;
        if (bus.req_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL abort_in_wait: ready=%b, required 0", bus.req_ready);
        end
        reset = 1'b0;
        #1;
        checks++;
        if ({bus.req_ready, bus.rsp_valid, bus.rsp_err} !== 3'b100 || bus.rsp_rdata !== 32'h0) begin
            errors++;
            $display("[TB] FAIL abort_reset_outputs: ready/valid/err=%b%b%b rdata=%h, required 100 and 00000000",
                     bus.req_ready, bus.rsp_valid, bus.rsp_err, bus.rsp_rdata);
        end
        @(negedge clk);
        reset = 1'b1;
        transact(1'b0, 1'b0, 1'b1, 9'h020, 32'h0, F3_W, rd, er, lat);
        checks++;
        if (rd !== 32'h12345678) begin
            errors++;
            $display("[TB] FAIL abort_store_dropped: rdata=%h, required 12345678", rd);
        end
    endtask

    task automatic test_misalign();
        logic [31:0] rd; logic er; int lat;
        logic [31:0] exp_lw, exp_after; logic exp_err;
`ifdef DMEM_MISALIGN_CHECK_EN
        exp_lw = 32'h0; exp_err = 1'b1; exp_after = 32'hCAFE12EF;
`else
        exp_lw = 32'hCAFE12EF; exp_err = 1'b0; exp_after = 32'hBEEF12EF;
`endif
        transact(1'b0, 1'b0, 1'b1, 9'h011, 32'h0, F3_W, rd, er, lat);
        checks++;
        if (rd !== exp_lw || er !== exp_err || lat !== 2) begin
            errors++;
            $display("[TB] FAIL misalign_lw: rdata=%h err=%b lat=%0d, required %h err=%b lat=2", rd, er, lat, exp_lw, exp_err);
        end
        transact(1'b0, 1'b1, 1'b0, 9'h013, 32'h0000BEEF, F3_H, rd, er, lat);
        checks++;
        if (rd !== 32'h0 || er !== exp_err) begin
            errors++;
            $display("[TB] FAIL misalign_sh: rdata=%h err=%b, required 00000000 err=%b", rd, er, exp_err);
        end
        transact(1'b0, 1'b0, 1'b1, 9'h010, 32'h0, F3_W, rd, er, lat);
        checks++;
        if (rd !== exp_after || er !== 1'b0) begin
            errors++;
            $display("[TB] FAIL misalign_mem: rdata=%h err=%b, required %h err=0", rd, er, exp_after);
        end
        transact(1'b0, 1'b0, 1'b1, 9'h011, 32'h0, F3_BU, rd, er, lat);
        checks++;
        if (rd !== 32'h00000012 || er !== 1'b0) begin
            errors++;
            $display("[TB] FAIL aligned_lbu: rdata=%h err=%b, required 00000012 err=0", rd, er);
        end
    endtask

    task automatic test_zero_wait();
        logic [31:0] rd; logic er; int lat;
        transact(1'b1, 1'b1, 1'b0, 9'h010, 32'hDEADBEEF, F3_W, rd, er, lat);
        checks++;
        if (lat !== 1 || rd !== 32'h0) begin
            errors++;
            $display("[TB] FAIL fast_sw: lat=%0d rdata=%h, required lat=1 rdata=00000000", lat, rd);
        end
        transact(1'b1, 1'b0, 1'b1, 9'h010, 32'h0, F3_W, rd, er, lat);
        checks++;
        if (lat !== 1 || rd !== 32'hDEADBEEF) begin
            errors++;
            $display("[TB] FAIL fast_lw: lat=%0d rdata=%h, required lat=1 rdata=deadbeef", lat, rd);
        end
        transact(1'b1, 1'b0, 1'b1, 9'h012, 32'h0, F3_H, rd, er, lat);
        checks++;
        if (lat !== 1 || rd !== 32'hFFFFDEAD) begin
            errors++;
            $display("[TB] FAIL fast_lh: lat=%0d rdata=%h, required lat=1 rdata=ffffdead", lat, rd);
        end
        @(negedge clk);
        checks++;
        if (bus_fast.rsp_valid !== 1'b0 || bus_fast.req_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL fast_single_pulse: valid=%b ready=%b, required 0 1", bus_fast.rsp_valid, bus_fast.req_ready);
        end
    endtask

    initial begin
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_re = 1'b0;
        bus.req_addr = '0; bus.req_wdata = '0; bus.req_funct3 = '0;
        bus_fast.req_valid = 1'b0; bus_fast.req_we = 1'b0; bus_fast.req_re = 1'b0;
        bus_fast.req_addr = '0; bus_fast.req_wdata = '0; bus_fast.req_funct3 = '0;
        test_reset();
        test_word();
        test_subword_load();
        test_subword_store();
        test_back_to_back();
        test_reset_abort();
        test_misalign();
        test_zero_wait();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
